uart_rx_top: RTL and testbench
==============================

# uart_rx_top

Serial receiver for the UART 16550 datapath. It sits directly downstream of the transmitter on the serial line, or on the far end of the link. It samples the `rx` line at 16× oversampling using the shared `baud_pulse` tick and deframes start, data (5–8 bits), optional parity and stop. Each received character is written into the RX FIFO with a one-cycle `push`, together with its parity-, framing- and break-error flags. LCR fields (`wls`, `pen`, `eps`, `sticky_parity`) are the same controls the transmitter uses.

## Interface
No parameters.
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset; synchronous, active-high
- `baud_pulse`  in  1  one-`clk` enable at 16× baud rate
- `rx`  in  1  asynchronous serial input; idle high
- `pen`  in  1  parity enable (LCR)
- `eps`  in  1  even parity select (LCR)
- `sticky_parity`  in  1  stick parity (LCR)
- `wls`  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- `push`  out  1  one-`clk` strobe: write `{bi,fe,pe,dout}` into the RX FIFO
- `dout`  out  8  received character, LSB-aligned; bits above the word length are 0
- `pe`  out  1  parity error for the `dout` character
- `fe`  out  1  framing error: stop bit sampled low
- `bi`  out  1  break: data, parity (if enabled) and stop all sampled 0

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer every `clk`, giving `rx_s`. Both flops reset to 1.
- **Enable.** The FSM, `count`, `bitcnt`, the shift register and `rx_prev` advance only in `clk` cycles with `baud_pulse`=1. Otherwise they hold.
- **`rx_prev`.** Holds `rx_s` from the previous tick. Reset value is 1.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** If `rx_s`=0 and `rx_prev`=1 (falling edge), set `count`←7 and go to START. A line held low never re-triggers, so no start is detected until the line has been seen high.
- **START.** Decrement `count`. At `count`=0 (mid-start-bit):
  - `rx_s`=0 → `count`←15, `bitcnt`←`wls`+4, clear the shift register, go to DATA.
  - `rx_s`=1 → false start; go to IDLE with no `push`.
- **DATA.** Decrement `count`. At `count`=0:
  - Shift in the bit: `shreg`←{`rx_s`,`shreg[7:1]`}. Bits arrive LSB first.
  - Set `count`←15.
  - If `bitcnt`=0, go to PARITY when `pen`=1, else STOP. Otherwise decrement `bitcnt`.
- **Data alignment.** `data` = `shreg` >> (3−`wls`), zero-extended to 8 bits.
- **PARITY.** At `count`=0, sample the parity bit and set `count`←15, then go to STOP.
- **Expected parity** is selected by {`sticky_parity`,`eps`}:
  - 00 → ~^`data` (odd)
  - 01 → ^`data` (even)
  - 10 → 1
  - 11 → 0
- **`pe`** = (sampled parity ≠ expected). It is 0 when `pen`=0.
- **STOP.** At `count`=0, sample the stop bit, register the outputs below, and go to IDLE. The tick that samples the stop bit also updates `rx_prev`.
  - `dout`←`data`
  - `fe`←~`rx_s`
  - `pe` as defined above
  - `bi`←(`data`==0 && `rx_s`==0 && (!`pen` || parity bit==0))
  - `push`←1
- **Stop bits.** Only the first stop bit is checked. The receiver has no `stb` input.
- **LCR changes mid-frame** are not supported. Inputs are sampled as they are at each decision point.
- **Mid-frame reset:** any state goes to IDLE in the next cycle with no `push`.

## Timing
- **Reset values:** `push`=0, `dout`=0, `pe`=0, `fe`=0, `bi`=0, state=IDLE, `count`=0, `bitcnt`=0, `rx_prev`=1, synchronizer flops=1.
- **Tick schedule,** with T0 = the tick that detects the start edge:
  - start check at T8
  - data bit *i* sampled at T24+16*i*
  - parity at T24+16*n*, where *n* = data bit count
  - stop at T24+16(*n*+`pen`)
- **Input latency.** The synchronizer adds 2 `clk` cycles between `rx` and `rx_s`.
- **`push` timing.** `push` is high for exactly one `clk`: the cycle after the stop-sample tick's clock edge. It deasserts on the next edge regardless of `baud_pulse`.
- **Output hold.** `dout`, `pe`, `fe` and `bi` become valid with `push` and hold until the next `push` or reset.
- **FIFO flow control.** There is no backpressure; the RX FIFO must accept every `push`.
- **Earliest next start.** A new start edge can be detected on the first tick after the STOP decision.

## Test plan
- **8N1 receive.** `wls`=11, `pen`=0; drive 0x13 at 16 ticks/bit → one `push`, `dout`=0x13, `pe`=`fe`=`bi`=0, `push` on the cycle after tick T152.
- **Even parity, both polarities.** `wls`=11, `pen`=1, `eps`=1; send 0x13 with parity 1 → `pe`=0. Repeat with parity 0 → `pe`=1, `dout`=0x13.
- **5-bit stick parity.** `wls`=00, `pen`=1, `sticky_parity`=1, `eps`=0; send 0x15 with parity 0 → `dout`=0x15, `pe`=1. Send with parity 1 → `pe`=0.
- **Framing error and break.**
  - 0x55 with stop=0, then line high → `fe`=1, `bi`=0.
  - Hold `rx` low for 300 ticks → exactly one `push` with `dout`=0, `fe`=1, `bi`=1. No further `push` until the line goes high and a new frame arrives, which then receives correctly.
- **False start.** A 4-tick low glitch → no `push`, FSM back in IDLE. A valid 0xA5 frame immediately after → `dout`=0xA5.
- **Mid-frame reset.** Assert `rst` for 1 cycle during DATA bit 3 → all outputs at their reset values, no `push`. The next full frame (0x3C) is received correctly.

Source files
------------

// File: rtl/uart_rx_top.sv
// UART 16550 serial receiver.
// Oversamples the serial line at 16x baud using the shared baud_pulse tick,
// deframes start / 5-8 data bits / optional parity / first stop bit, and
// emits each character with a one-cycle push plus parity, framing and break
// flags for the RX FIFO.
//
// Tick schedule (T0 = tick that sees the falling start edge):
//   start re-check at T8, data bit i at T24+16*i, parity at T24+16*n,
//   stop at T24+16*(n+pen); push is high for the clk cycle after the stop tick.
//
// Handshake: push_o is a one-cycle valid strobe with no ready; the consumer
// must accept every push. dout_o/pe_o/fe_o/bi_o are valid with push_o and
// hold until the next push or reset.
module uart_rx_top (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       baud_pulse_i,
   input  logic       rx_i,
   input  logic       pen_i,
   input  logic       eps_i,
   input  logic       sticky_parity_i,
   input  logic [1:0] wls_i,
   output logic       push_o,
   output logic [7:0] dout_o,
   output logic       pe_o,
   output logic       fe_o,
   output logic       bi_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t      state_q;
   logic [1:0]  sync_q;
   logic        rx_prev_q;
   logic [3:0]  count_q;
   logic [2:0]  bitcnt_q;
   logic [7:0]  shreg_q;
   logic        par_q;
   logic        push_q;
   logic [7:0]  dout_q;
   logic        pe_q;
   logic        fe_q;
   logic        bi_q;

   logic        rx_s;
   logic [7:0]  data_d;
   logic        exp_par_d;
   logic        pe_d;
   logic        bi_d;

   assign rx_s = sync_q[1];

   // Two-flop synchronizer for the asynchronous serial input; idles high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

   // Received bits enter at bit 7, so shorter words need shifting down to bit 0.
   assign data_d = shreg_q >> (2'd3 - wls_i);

   // Expected parity bit, then the error flags evaluated at the stop decision.
   always_comb begin
      exp_par_d = 1'b0;
      case ({sticky_parity_i, eps_i})
         2'b00:   exp_par_d = ~^data_d;
         2'b01:   exp_par_d = ^data_d;
         2'b10:   exp_par_d = 1'b1;
         default: exp_par_d = 1'b0;
      endcase
      pe_d = pen_i & (par_q != exp_par_d);
      bi_d = (data_d == 8'h00) & ~rx_s & (~pen_i | ~par_q);
   end

   // Deframing FSM; all state advances only on baud ticks, push clears every clk.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rx_prev_q <= 1'b1;
         count_q   <= 4'd0;
         bitcnt_q  <= 3'd0;
         shreg_q   <= 8'h00;
         par_q     <= 1'b0;
         push_q    <= 1'b0;
         dout_q    <= 8'h00;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         bi_q      <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (baud_pulse_i) begin
            rx_prev_q <= rx_s;
            case (state_q)
               S_IDLE: begin
                  // Only a high-to-low transition starts a frame, so a line
                  // stuck low cannot retrigger after a break.
                  if (!rx_s && rx_prev_q) begin
                     count_q <= 4'd7;
                     state_q <= S_START;
                  end
               end
               S_START: begin
                  if (count_q == 4'd0) begin
                     if (!rx_s) begin
                        count_q  <= 4'd15;
                        bitcnt_q <= {1'b0, wls_i} + 3'd4;
                        shreg_q  <= 8'h00;
                        state_q  <= S_DATA;
                     end else begin
                        // Line went back high by mid-bit: glitch, not a start.
                        state_q <= S_IDLE;
                     end
                  end else begin
                     count_q <= count_q - 4'd1;
                  end
               end
               S_DATA: begin
                  if (count_q == 4'd0) begin
                     shreg_q <= {rx_s, shreg_q[7:1]};
                     count_q <= 4'd15;
                     if (bitcnt_q == 3'd0) begin
                        state_q <= pen_i ? S_PARITY : S_STOP;
                     end else begin
                        bitcnt_q <= bitcnt_q - 3'd1;
                     end
                  end else begin
                     count_q <= count_q - 4'd1;
                  end
               end
               S_PARITY: begin
                  if (count_q == 4'd0) begin
                     par_q   <= rx_s;
                     count_q <= 4'd15;
                     state_q <= S_STOP;
                  end else begin
                     count_q <= count_q - 4'd1;
                  end
               end
               S_STOP: begin
                  if (count_q == 4'd0) begin
                     dout_q  <= data_d;
                     fe_q    <= ~rx_s;
                     pe_q    <= pe_d;
                     bi_q    <= bi_d;
                     push_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     count_q <= count_q - 4'd1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign push_o  = push_q;
   assign dout_o  = dout_q;
   assign pe_o    = pe_q;
   assign fe_o    = fe_q;
   assign bi_o    = bi_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Testbench for uart_rx_top: drives serial frames at 16 ticks per bit and
// compares every push against a frame-level reference model.
module tb_uart_rx_top;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_pulse = 1'b0;
   logic       rx = 1'b1;
   logic       pen = 1'b0;
   logic       eps = 1'b0;
   logic       sticky = 1'b0;
   logic [1:0] wls = 2'b11;

   logic       push;
   logic [7:0] dout;
   logic       pe;
   logic       fe;
   logic       bi;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int tick_n = 0;
   int baud_div = 0;
   int width_err = 0;
   logic push_prev = 1'b0;

   // {bi, fe, pe, dout}
   logic [10:0] got_q[$];
   int          got_tick_q[$];
   logic [10:0] exp_q[$];
   int          exp_tick_q[$];

   uart_rx_top dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .baud_pulse_i    (baud_pulse),
      .rx_i            (rx),
      .pen_i           (pen),
      .eps_i           (eps),
      .sticky_parity_i (sticky),
      .wls_i           (wls),
      .push_o          (push),
      .dout_o          (dout),
      .pe_o            (pe),
      .fe_o            (fe),
      .bi_o            (bi),
      .state_o         (state)
   );

   // ---------------- clock / reset / tick generation ----------------
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         baud_div = (baud_div + 1) % 4;
         baud_pulse = (baud_div == 0);
      end
   end

   always @(posedge clk) begin
      if (baud_pulse) tick_n <= tick_n + 1;
   end

   // Capture every push with the tick index of the edge that raised it.
   always @(negedge clk) begin
      if (push === 1'b1) begin
         got_q.push_back({bi, fe, pe, dout});
         got_tick_q.push_back(tick_n);
         if (push_prev === 1'b1) width_err++;
      end
      push_prev = push;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [10:0] expect_frame(input logic [7:0] data, input int nbits,
                                                 input logic with_par, input logic eps_v,
                                                 input logic sticky_v, input logic par,
                                                 input logic stop);
      logic [7:0] d = 8'h00;
      int ones = 0;
      logic exp_par;
      logic pe_v;
      logic fe_v;
      logic bi_v;
      for (int i = 0; i < nbits; i++) begin
         d[i] = data[i];
         ones += int'(data[i]);
      end
      if (sticky_v) exp_par = !eps_v;
      else if (eps_v) exp_par = (ones % 2 == 1);
      else exp_par = (ones % 2 == 0);
      pe_v = with_par && (par != exp_par);
      fe_v = !stop;
      bi_v = (d == 8'h00) && !stop && (!with_par || !par);
      return {bi_v, fe_v, pe_v, d};
   endfunction

   // ---------------- driver tasks ----------------
   // Returns 1 time unit after a clk edge that carried a baud tick.
   task automatic wait_tick();
      @(posedge clk);
      while (baud_pulse !== 1'b1) @(posedge clk);
      #1;
   endtask

   task automatic hold_line(input logic v, input int n);
      rx = v;
      repeat (n) wait_tick();
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input logic with_par,
                             input logic par, input logic stop, output int start_tick);
      start_tick = tick_n;
      hold_line(1'b0, 16);
      for (int i = 0; i < nbits; i++) hold_line(data[i], 16);
      if (with_par) hold_line(par, 16);
      hold_line(stop, 16);
      rx = 1'b1;
   endtask

   // Sends one frame with the current LCR settings and queues the expectation.
   task automatic run_frame(input logic [7:0] data, input logic par, input logic stop);
      int st;
      int n;
      n = int'(wls) + 5;
      exp_q.push_back(expect_frame(data, n, pen, eps, sticky, par, stop));
      send_frame(data, n, pen, par, stop, st);
      // Start driven just after tick st, so T0 is tick st+1.
      exp_tick_q.push_back(st + 1 + 24 + 16 * (n + int'(pen)));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({push, dout, pe, fe, bi, state} !== 14'd0) begin
         errors++;
         $display("FAIL reset_values: got %h expected 0", {push, dout, pe, fe, bi, state});
      end
      rst = 1'b0;
      repeat (4) wait_tick();
      checks++;
      if ({push, dout, pe, fe, bi, state} !== 14'd0) begin
         errors++;
         $display("FAIL reset_idle_hold: got %h expected 0", {push, dout, pe, fe, bi, state});
      end
   endtask

   task automatic test_8n1();
      logic [10:0] g;
      int gt;
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky = 1'b0;
      run_frame(8'h13, 1'b0, 1'b1);
      hold_line(1'b1, 4);
      checks++;
      if (got_q.size() != 1) begin
         errors++;
         $display("FAIL 8n1_push_count: got %0d expected 1", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); gt = got_tick_q.pop_front();
         checks++;
         if (g !== exp_q[0]) begin
            errors++;
            $display("FAIL 8n1_frame: got %h expected %h", g, exp_q[0]);
         end
         checks++;
         if (gt !== exp_tick_q[0]) begin
            errors++;
            $display("FAIL 8n1_push_tick: got %0d expected %0d", gt, exp_tick_q[0]);
         end
         void'(exp_q.pop_front()); void'(exp_tick_q.pop_front());
      end
      checks++;
      if ({dout, pe, fe, bi} !== {8'h13, 3'b000}) begin
         errors++;
         $display("FAIL 8n1_output_hold: got %h expected %h", {dout, pe, fe, bi}, {8'h13, 3'b000});
      end
      got_q.delete(); got_tick_q.delete(); exp_q.delete(); exp_tick_q.delete();
   endtask

   task automatic test_parity(input string name);
      logic [10:0] g;
      int gt;
      int exp_n;
      exp_n = exp_q.size();
      checks++;
      if (got_q.size() != exp_n) begin
         errors++;
         $display("FAIL %s_push_count: got %0d expected %0d", name, got_q.size(), exp_n);
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); gt = got_tick_q.pop_front();
         checks++;
         if (g !== exp_q[0]) begin
            errors++;
            $display("FAIL %s_frame: got %h expected %h", name, g, exp_q[0]);
         end
         checks++;
         if (gt !== exp_tick_q[0]) begin
            errors++;
            $display("FAIL %s_push_tick: got %0d expected %0d", name, gt, exp_tick_q[0]);
         end
         void'(exp_q.pop_front()); void'(exp_tick_q.pop_front());
      end
      got_q.delete(); got_tick_q.delete(); exp_q.delete(); exp_tick_q.delete();
   endtask

   task automatic test_even_parity();
      wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky = 1'b0;
      run_frame(8'h13, 1'b1, 1'b1);
      run_frame(8'h13, 1'b0, 1'b1);
      hold_line(1'b1, 4);
      test_parity("even_parity");
   endtask

   task automatic test_stick_parity();
      wls = 2'b00; pen = 1'b1; eps = 1'b0; sticky = 1'b1;
      run_frame(8'h15, 1'b0, 1'b1);
      run_frame(8'h15, 1'b1, 1'b1);
      eps = 1'b1;
      run_frame(8'h0A, 1'b1, 1'b1);
      hold_line(1'b1, 4);
      test_parity("stick_parity");
   endtask

   task automatic test_framing();
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky = 1'b0;
      run_frame(8'h55, 1'b0, 1'b0);
      hold_line(1'b1, 8);
      test_parity("framing");
   endtask

   task automatic test_break();
      int st;
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky = 1'b0;
      st = tick_n;
      exp_q.push_back(expect_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_tick_q.push_back(st + 1 + 24 + 16 * 8);
      hold_line(1'b0, 300);
      checks++;
      if (got_q.size() != 1) begin
         errors++;
         $display("FAIL break_single_push: got %0d pushes expected 1", got_q.size());
      end
      hold_line(1'b1, 20);
      run_frame(8'h6B, 1'b0, 1'b1);
      hold_line(1'b1, 4);
      test_parity("break");
   endtask

   task automatic test_false_start();
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky = 1'b0;
      hold_line(1'b0, 4);
      hold_line(1'b1, 16);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL false_start_no_push: got %0d pushes expected 0", got_q.size());
      end
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL false_start_idle: got state %0d expected 0", state);
      end
      run_frame(8'hA5, 1'b0, 1'b1);
      hold_line(1'b1, 4);
      test_parity("false_start");
   endtask

   task automatic test_mid_reset();
      logic [7:0] data;
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky = 1'b0;
      data = 8'h3C;
      hold_line(1'b0, 16);
      for (int i = 0; i < 3; i++) hold_line(data[i], 16);
      hold_line(data[3], 8);
      rst = 1'b1;
      rx = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({push, dout, pe, fe, bi, state} !== 14'd0) begin
         errors++;
         $display("FAIL mid_reset_values: got %h expected 0", {push, dout, pe, fe, bi, state});
      end
      hold_line(1'b1, 200);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL mid_reset_no_push: got %0d pushes expected 0", got_q.size());
      end
      run_frame(8'h3C, 1'b0, 1'b1);
      hold_line(1'b1, 4);
      test_parity("mid_reset");
   endtask

   task automatic test_back_to_back();
      wls = 2'b11; pen = 1'b1; eps = 1'b0; sticky = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      end
      hold_line(1'b1, 4);
      test_parity("back_to_back");
   endtask

   task automatic test_random();
      logic stop;
      for (int i = 0; i < 16; i++) begin
         wls = 2'($urandom_range(0, 3));
         pen = 1'($urandom_range(0, 1));
         eps = 1'($urandom_range(0, 1));
         sticky = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 3) != 0);
         run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), stop);
         hold_line(1'b1, stop ? $urandom_range(0, 3) : $urandom_range(1, 3));
      end
      hold_line(1'b1, 4);
      test_parity("random");
   endtask

   task automatic test_push_width();
      checks++;
      if (width_err != 0) begin
         errors++;
         $display("FAIL push_width: got %0d multi-cycle pushes expected 0", width_err);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_even_parity();
      test_stick_parity();
      test_framing();
      test_break();
      test_false_start();
      test_mid_reset();
      test_back_to_back();
      test_random();
      test_push_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
